uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmit path. It accepts a parallel byte through a valid/ack handshake and holds it stable for the 8-bit serializer. It paces that serializer one bit per baud tick, computes optional parity, and multiplexes start, data, parity and stop bits onto the TX line. It sits between the host-side byte source and the serial pin, with the serializer as its only datapath slave.

---
 rtl/uart_tx_ctrl_if.sv | 25 ++
 rtl/uart_tx_ctrl.sv | 97 +++++++++
 tb/tb_uart_tx_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake for the UART transmit frame sequencer.
// The master offers a byte plus parity settings; the slave acknowledges acceptance.
interface uart_tx_ctrl_if;
    logic       DATA_VALID;
    logic [7:0] P_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       DATA_ACK;

    modport master (
        output DATA_VALID,
        output P_DATA,
        output PAR_EN,
        output PAR_TYP,
        input  DATA_ACK
    );

    modport slave (
        input  DATA_VALID,
        input  P_DATA,
        input  PAR_EN,
        input  PAR_TYP,
        output DATA_ACK
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: latches a host byte, paces the serializer per baud tick
// and muxes start, data, parity and stop bits onto the TX line.
module uart_tx_ctrl #(
    parameter int unsigned STOP_BITS  = 1,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_ctrl_if.slave        host,
    input  logic                 BAUD_TICK,
    input  logic                 SER_DONE,
    input  logic                 SER_DATA,
    output logic                 SER_EN,
    output logic [7:0]           SER_P_DATA,
    output logic                 BUSY,
    output logic                 TX_OUT
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q;
    logic   par_bit_q;
    logic   par_en_q;
    logic   stop_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= StIdle;
            BUSY          <= 1'b0;
            host.DATA_ACK <= 1'b0;
            SER_P_DATA    <= 8'h00;
            par_bit_q     <= 1'b0;
            par_en_q      <= 1'b0;
            stop_cnt_q    <= 1'b0;
        end else begin
            host.DATA_ACK <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A tick coinciding with acceptance is deliberately not used for START.
                    if (host.DATA_VALID) begin
                        SER_P_DATA    <= host.P_DATA;
                        par_bit_q     <= (^host.P_DATA) ^ host.PAR_TYP;
                        par_en_q      <= host.PAR_EN;
                        host.DATA_ACK <= 1'b1;
                        BUSY          <= 1'b1;
                        state_q       <= StArmed;
                    end
                end
                StArmed: begin
                    if (BAUD_TICK) state_q <= StStart;
                end
                StStart: begin
                    if (BAUD_TICK) state_q <= StData;
                end
                StData: begin
                    if (BAUD_TICK && SER_DONE) state_q <= par_en_q ? StParity : StStop;
                end
                StParity: begin
                    if (BAUD_TICK) state_q <= StStop;
                end
                StStop: begin
                    if (BAUD_TICK) begin
                        if (STOP_BITS == 2 && !stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            stop_cnt_q <= 1'b0;
                            BUSY       <= 1'b0;
                            state_q    <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Serializer advances on the same edge that ends START or a non-final data bit.
    assign SER_EN = BAUD_TICK && ((state_q == StStart) || (state_q == StData && !SER_DONE));

    always_comb begin
        TX_OUT = IDLE_LEVEL;
        unique case (state_q)
            StStart:  TX_OUT = ~IDLE_LEVEL;
            StData:   TX_OUT = SER_DATA;
            StParity: TX_OUT = par_bit_q;
            default:  TX_OUT = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (1 and 2 stop bits), a serializer model,
// a reference frame builder and a decoupled line monitor.
module tb_uart_tx_ctrl;

    localparam logic IDLE    = 1'b1;
    localparam int   TIMEOUT = 4000;

    typedef struct {
        logic [11:0] bits;
        int          n;
        logic [7:0]  b;
        int          inst;
    } frame_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [3:0]      tcnt;
    logic            tick;
    logic [1:0]      dv;
    logic [7:0]      pd;
    logic            pen;
    logic            ptyp;
    logic [1:0]      ack;
    logic [1:0]      ser_en;
    logic [1:0]      ser_done;
    logic [1:0]      ser_data;
    logic [1:0]      busy;
    logic [1:0]      tx;
    logic [1:0][7:0] spd;
    logic [1:0][3:0] scnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_tx_ctrl_if bus0();
    uart_tx_ctrl_if bus1();

    assign bus0.DATA_VALID = dv[0];
    assign bus0.P_DATA     = pd;
    assign bus0.PAR_EN     = pen;
    assign bus0.PAR_TYP    = ptyp;
    assign bus1.DATA_VALID = dv[1];
    assign bus1.P_DATA     = pd;
    assign bus1.PAR_EN     = pen;
    assign bus1.PAR_TYP    = ptyp;
    assign ack             = {bus1.DATA_ACK, bus0.DATA_ACK};

    uart_tx_ctrl #(.STOP_BITS(1), .IDLE_LEVEL(IDLE)) dut0 (
        .CLK        (CLK),
        .RST        (RST),
        .host       (bus0),
        .BAUD_TICK  (tick),
        .SER_DONE   (ser_done[0]),
        .SER_DATA   (ser_data[0]),
        .SER_EN     (ser_en[0]),
        .SER_P_DATA (spd[0]),
        .BUSY       (busy[0]),
        .TX_OUT     (tx[0])
    );

    uart_tx_ctrl #(.STOP_BITS(2), .IDLE_LEVEL(IDLE)) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .host       (bus1),
        .BAUD_TICK  (tick),
        .SER_DONE   (ser_done[1]),
        .SER_DATA   (ser_data[1]),
        .SER_EN     (ser_en[1]),
        .SER_P_DATA (spd[1]),
        .BUSY       (busy[1]),
        .TX_OUT     (tx[1])
    );

    // Baud tick: one CLK in every 16.
    always @(posedge CLK or negedge RST) begin
        if (!RST) tcnt <= 4'd0;
        else      tcnt <= tcnt + 4'd1;
    end
    assign tick = (tcnt == 4'd15);

    always @(posedge CLK) cyc <= cyc + 1;

    // Serializer model: presents bit k of the latched byte on the k-th SER_EN edge.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scnt     <= '0;
            ser_data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    scnt[i] <= 4'd0;
                end else if (ser_en[i]) begin
                    ser_data[i] <= spd[i][scnt[i][2:0]];
                    scnt[i]     <= scnt[i] + 4'd1;
                end
            end
        end
    end
    assign ser_done[0] = (scnt[0] == 4'd8);
    assign ser_done[1] = (scnt[1] == 4'd8);

    task automatic chk(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t mk_frame(input int i, input logic [7:0] b, input bit pe,
                                        input bit pt);
        frame_t f;
        int     n;
        f.bits = '0;
        f.b    = b;
        f.inst = i;
        n      = 0;
        f.bits[n] = ~IDLE;
        n++;
        for (int k = 0; k < 8; k++) begin
            f.bits[n] = b[k];
            n++;
        end
        if (pe) begin
            f.bits[n] = (($countones(b) % 2) == 1) ^ pt;
            n++;
        end
        for (int k = 0; k < i + 1; k++) begin
            f.bits[n] = IDLE;
            n++;
        end
        f.n = n;
        return f;
    endfunction

    frame_t      exp_q[$];
    frame_t      cur[2];
    bit          in_frame[2];
    bit          end_chk[2];
    bit          en_prev[2];
    bit          en_err[2];
    bit          hold_err[2];
    int          pos[2];
    int          secnt[2];
    int          ack_cnt[2];
    int          last_end[2];
    int          gap_req[2];
    int          gap_done[2];
    logic [11:0] got[2];

    // Monitor: a frame starts when the line leaves idle; each tick cycle ends one bit.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                in_frame[i] = 1'b0;
                end_chk[i]  = 1'b0;
                en_prev[i]  = 1'b0;
            end else begin
                if (ack[i]) ack_cnt[i]++;
                if (end_chk[i]) begin
                    chk("busy_fall", busy[i] === 1'b0, busy[i], 0);
                    end_chk[i]  = 1'b0;
                    last_end[i] = cyc;
                end
                if (!in_frame[i] && ser_en[i]) chk("stray_ser_en", 1'b0, ser_en[i], 0);
                if (!in_frame[i] && tx[i] === ~IDLE) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                        chk("unexpected_start", 1'b0, tx[i], IDLE);
                    end else begin
                        cur[i]      = exp_q.pop_front();
                        in_frame[i] = 1'b1;
                        pos[i]      = 0;
                        secnt[i]    = 0;
                        en_err[i]   = 1'b0;
                        hold_err[i] = 1'b0;
                        got[i]      = '0;
                        if (gap_done[i] != gap_req[i]) begin
                            chk("b2b_gap", (cyc - last_end[i]) <= 17, cyc - last_end[i], 17);
                            gap_done[i] = gap_req[i];
                        end
                    end
                end
                if (in_frame[i]) begin
                    if (ser_en[i]) begin
                        secnt[i]++;
                        if (en_prev[i]) en_err[i] = 1'b1;
                    end
                    if (busy[i] !== 1'b1 || spd[i] !== cur[i].b) hold_err[i] = 1'b1;
                    if (tick) begin
                        got[i][pos[i]] = tx[i];
                        pos[i]++;
                        if (pos[i] == cur[i].n) begin
                            chk("frame_bits", got[i] === cur[i].bits, got[i], cur[i].bits);
                            chk("ser_en_count", secnt[i] == 8, secnt[i], 8);
                            chk("busy_and_data_held", !hold_err[i], hold_err[i], 0);
                            chk("ser_en_spacing", !en_err[i], en_err[i], 0);
                            in_frame[i] = 1'b0;
                            end_chk[i]  = 1'b1;
                        end
                    end
                end
                en_prev[i] = ser_en[i];
            end
        end
    end

    task automatic send(input int i, input logic [7:0] b, input bit pe, input bit pt,
                        input bit hold);
        int t;
        t     = 0;
        pd    = b;
        pen   = pe;
        ptyp  = pt;
        dv[i] = 1'b1;
        do begin
            @(negedge CLK);
            t++;
        end while (!ack[i] && t < TIMEOUT);
        if (!ack[i]) begin
            chk("ack_timeout", 1'b0, t, TIMEOUT);
        end else begin
            chk("armed_line_idle", tx[i] === IDLE, tx[i], IDLE);
            chk("latched_byte", spd[i] === b, spd[i], b);
            exp_q.push_back(mk_frame(i, b, pe, pt));
        end
        if (!hold) dv[i] = 1'b0;
        // Inputs change after acceptance; only the latched copies may matter.
        pd   = 8'($urandom);
        pen  = 1'($urandom);
        ptyp = 1'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_frame[i] || end_chk[i] || busy[i]) && t < TIMEOUT) begin
            @(negedge CLK);
            t++;
        end
        if (t >= TIMEOUT) chk("idle_timeout", 1'b0, t, TIMEOUT);
        @(negedge CLK);
    endtask

    task automatic wait_pos(input int i, input int p);
        int t;
        t = 0;
        while (!(in_frame[i] && pos[i] >= p) && t < TIMEOUT) begin
            @(negedge CLK);
            t++;
        end
        if (t >= TIMEOUT) chk("pos_timeout", 1'b0, pos[i], p);
    endtask

    initial begin
        int a0;
        int t;
        dv   = 2'b00;
        pd   = 8'h00;
        pen  = 1'b0;
        ptyp = 1'b0;
        #1 RST = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", tx[i] === IDLE, tx[i], IDLE);
            chk("rst_busy", busy[i] === 1'b0, busy[i], 0);
            chk("rst_ack", ack[i] === 1'b0, ack[i], 0);
            chk("rst_ser_en", ser_en[i] === 1'b0, ser_en[i], 0);
            chk("rst_ser_p_data", spd[i] === 8'h00, spd[i], 0);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 8'h03, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        send(0, 8'h07, 1'b1, 1'b1, 1'b0);
        wait_idle(0);
        send(0, 8'h07, 1'b1, 1'b0, 1'b0);
        wait_idle(0);
        send(1, 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_idle(1);

        // New byte offered mid-frame must be ignored.
        send(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_pos(0, 3);
        a0    = ack_cnt[0];
        pd    = 8'h3C;
        dv[0] = 1'b1;
        repeat (20) @(negedge CLK);
        chk("midframe_ser_p_data", spd[0] === 8'h55, spd[0], 8'h55);
        dv[0] = 1'b0;
        @(negedge CLK);
        chk("midframe_no_ack", ack_cnt[0] == a0, ack_cnt[0], a0);
        wait_idle(0);

        // Back-to-back with DATA_VALID held high.
        send(0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_pos(0, 0);
        gap_req[0]++;
        send(0, 8'h22, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // Valid arriving in a tick cycle: acceptance must not consume the tick.
        for (int k = 0; k < 3; k++) begin
            t = 0;
            do begin
                @(negedge CLK);
                t++;
            end while (!tick && t < 64);
            send(k % 2, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            wait_idle(k % 2);
        end

        // Asynchronous reset during data bit 4.
        send(0, 8'hC3, 1'b1, 1'b0, 1'b0);
        wait_pos(0, 5);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("abort_tx", tx[0] === IDLE, tx[0], IDLE);
        chk("abort_busy", busy[0] === 1'b0, busy[0], 0);
        chk("abort_ser_en", ser_en[0] === 1'b0, ser_en[0], 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(0, 8'h81, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        for (int k = 0; k < 30; k++) begin
            int i;
            i = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge CLK);
            send(i, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            wait_idle(i);
        end

        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
